// File: rtl/motion_seg_queue.sv
// Segment sequencer: queues (velocity, duration) segments and plays them back in order,
// holding each velocity for duration * TICK_DIV clocks, with seamless chaining and abort.
module motion_seg_queue #(
    parameter int DEPTH    = 8,
    parameter int TICK_DIV = 1000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [31:0]           seg_velocity,
    input  logic        [31:0]           seg_duration,
    input  logic                         seg_valid,
    output logic                         seg_ready,
    input  logic                         abort,
    output logic signed [31:0]           velocity,
    output logic                         busy,
    output logic                         seg_done,
    output logic                         underrun,
    output logic [$clog2(DEPTH):0]       fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      tick_q, tick_d;
    logic [31:0]        rem_q, rem_d;
    logic signed [31:0] vel_q, vel_d;
    logic               done_q, done_d, under_q, under_d;
    logic [CW-1:0]      count_q, count_d;
    logic [AW-1:0]      rd_q, rd_d, wr_q, wr_d;
    logic               push, pop, load;

    logic signed [31:0] vel_mem [DEPTH];
    logic        [31:0] dur_mem [DEPTH];

    // Ready looks only at the registered count, so a same-cycle pop never opens a full FIFO.
    assign seg_ready = (count_q < CW'(DEPTH)) && !abort;
    assign push      = seg_valid && seg_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            vel_mem[wr_q] <= seg_velocity;
            dur_mem[wr_q] <= seg_duration;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        rem_d   = rem_q;
        vel_d   = vel_q;
        done_d  = 1'b0;
        under_d = 1'b0;
        load    = 1'b0;
        if (abort) begin
            state_d = IDLE;
            vel_d   = '0;
            tick_d  = '0;
            rem_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    vel_d = '0;
                    if (count_q != '0) load = 1'b1;
                end
                RUN: begin
                    if (tick_q == '0) begin
                        tick_d = TW'(TICK_DIV - 1);
                        if (rem_q > 32'd1) begin
                            rem_d = rem_q - 32'd1;
                        end else if (rem_q == 32'd1) begin
                            done_d = 1'b1;
                            if (count_q != '0) begin
                                load = 1'b1;
                            end else begin
                                vel_d   = '0;
                                rem_d   = '0;
                                under_d = 1'b1;
                                state_d = IDLE;
                            end
                        end else if (count_q != '0) begin
                            // Hold segment: released only by a waiting successor.
                            done_d = 1'b1;
                            load   = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q - TW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (load) begin
            vel_d   = vel_mem[rd_q];
            rem_d   = dur_mem[rd_q];
            tick_d  = TW'(TICK_DIV - 1);
            state_d = RUN;
        end
    end

    assign pop     = load;
    assign wr_d    = abort ? '0 : wr_q + AW'(push);
    assign rd_d    = abort ? '0 : rd_q + AW'(pop);
    assign count_d = abort ? '0 : count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            rem_q   <= '0;
            vel_q   <= '0;
            done_q  <= 1'b0;
            under_q <= 1'b0;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            rem_q   <= rem_d;
            vel_q   <= vel_d;
            done_q  <= done_d;
            under_q <= under_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign velocity   = vel_q;
    assign busy       = (state_q == RUN);
    assign seg_done   = done_q;
    assign underrun   = under_q;
    assign fifo_count = count_q;
endmodule

// File: tb/tb_motion_seg_queue.sv
// Randomized bench: accepted segments go into a scoreboard queue; a negedge monitor
// derives expected outputs from segment start times and durations and compares every cycle.
module tb_motion_seg_queue;
    localparam int TD  = 4;
    localparam int DEP = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [31:0] seg_velocity = '0;
    logic        [31:0] seg_duration = '0;
    logic               seg_valid = 1'b0;
    logic               seg_ready;
    logic               abort = 1'b0;
    logic signed [31:0] velocity;
    logic               busy, seg_done, underrun;
    logic [3:0]         fifo_count;

    motion_seg_queue #(.DEPTH(DEP), .TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .seg_velocity(seg_velocity), .seg_duration(seg_duration),
        .seg_valid(seg_valid), .seg_ready(seg_ready), .abort(abort), .velocity(velocity),
        .busy(busy), .seg_done(seg_done), .underrun(underrun), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [31:0] v;
        logic        [31:0] d;
        longint             pe;   // edge at which the push lands
    } seg_t;

    seg_t   exp_q[$];
    seg_t   cur;
    bit     running = 0;
    bit     pend_abort = 0;
    longint st = 0;
    longint cyc = 0;
    int     vectors = 0;
    int     errs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic void start_seg();
        cur     = exp_q.pop_front();
        running = 1;
        st      = cyc;
    endfunction

    // Monitor / reference model: evaluates what the most recent edge should have produced.
    always @(negedge clk) begin
        bit     ev_done, ev_under, avail, exp_ready;
        longint el;
        seg_t   s;
        ev_done  = 0;
        ev_under = 0;
        if (reset) begin
            exp_q.delete();
            running    = 0;
            pend_abort = 0;
        end else begin
            avail = (exp_q.size() > 0) && (exp_q[0].pe < cyc);
            if (pend_abort) begin
                exp_q.delete();
                running = 0;
            end else if (running) begin
                el = cyc - st;
                if (el > 0 && el % TD == 0) begin
                    if (cur.d != 0 && el == longint'(cur.d) * TD) begin
                        ev_done = 1;
                        if (avail) start_seg();
                        else begin
                            running  = 0;
                            ev_under = 1;
                        end
                    end else if (cur.d == 0 && avail) begin
                        ev_done = 1;
                        start_seg();
                    end
                end
            end else if (avail) begin
                start_seg();
            end
            pend_abort = abort;
        end
        chk("velocity",   longint'(velocity), running ? longint'(cur.v) : 0);
        chk("busy",       longint'(busy),       longint'(running));
        chk("seg_done",   longint'(seg_done),   longint'(ev_done));
        chk("underrun",   longint'(underrun),   longint'(ev_under));
        chk("fifo_count", longint'(fifo_count), longint'(exp_q.size()));
        exp_ready = (exp_q.size() < DEP) && !abort;
        chk("seg_ready",  longint'(seg_ready),  longint'(exp_ready));
        if (!reset && seg_valid && exp_ready) begin
            s.v = seg_velocity;
            s.d = seg_duration;
            s.pe = cyc + 1;
            exp_q.push_back(s);
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_seg(input logic signed [31:0] v, input logic [31:0] d);
        int n;
        n = 0;
        seg_velocity = v;
        seg_duration = d;
        seg_valid    = 1'b1;
        #1;
        while (!seg_ready && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        vectors++;
        if (n >= 300) begin
            errs++;
            $display("FAIL push_timeout: seg_ready stayed %0b, needed 1", seg_ready);
        end
        @(posedge clk);
        #1;
        seg_valid = 1'b0;
    endtask

    initial begin
        // Reset and idle
        idle(3);
        reset = 1'b0;
        idle(20);
        // Single segment
        push_seg(1000, 3);
        idle(20);
        // Seamless chain
        push_seg(500, 2);
        push_seg(-700, 1);
        push_seg(32'sh7FFFFFFF, 1);
        idle(25);
        // Full FIFO with one segment executing
        push_seg(50, 2);
        idle(2);
        seg_duration = 1;
        seg_valid    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            seg_velocity = 2000 + i;
            idle(1);
        end
        seg_valid = 1'b0;
        idle(50);
        // Hold segment
        push_seg(300, 0);
        idle(40);
        push_seg(100, 1);
        idle(15);
        // Abort mid-run with a simultaneous offer
        for (int i = 0; i < 5; i++) push_seg(10 * (i + 1), 2);
        idle(3);
        abort        = 1'b1;
        seg_valid    = 1'b1;
        seg_velocity = 999;
        seg_duration = 1;
        idle(1);
        abort     = 1'b0;
        seg_valid = 1'b0;
        idle(10);
        // Async reset between edges
        for (int i = 0; i < 5; i++) push_seg(-20 * (i + 1), 2);
        idle(3);
        #2;
        reset = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(5);
        // Randomized traffic with occasional aborts
        for (int i = 0; i < 600; i++) begin
            seg_valid    = ($urandom_range(0, 99) < 30);
            seg_velocity = $urandom;
            seg_duration = $urandom_range(0, 3);
            abort        = ($urandom_range(0, 99) < 2);
            idle(1);
        end
        seg_valid = 1'b0;
        abort     = 1'b0;
        push_seg(7, 1);
        idle(60);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/motion_seg_queue.md
# motion_seg_queue

Segment sequencer upstream of the step generator: buffers (velocity, duration) motion segments from the host/bus side in a small FIFO and plays them back in order, driving the generator's signed `velocity` command for an exact number of timebase ticks per segment. It makes back-to-back segments seamless, returns the command to 0 when the queue underruns, and supports an immediate abort/flush. The step generator still applies its own acceleration and velocity limits downstream.

## Interface
- `DEPTH`, 8: FIFO entries. Must be a power of 2, at least 2.
- `TICK_DIV`, 1000: clocks per duration tick. Matches the step generator's acceleration update period.
- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `seg_velocity`  in  32 signed: velocity of the offered segment.
- `seg_duration`  in  32: segment length in ticks; 0 = hold.
- `seg_valid`  in  1: offered segment is valid.
- `seg_ready`  out  1: the FIFO can accept a segment this cycle.
- `abort`  in  1: synchronous flush/stop.
- `velocity`  out  32 signed: command to the step generator (registered).
- `busy`  out  1: a segment is executing (state RUN).
- `seg_done`  out  1: one-cycle pulse when a segment completes.
- `underrun`  out  1: one-cycle pulse when a segment completes with the FIFO empty.
- `fifo_count`  out  $clog2(DEPTH)+1: number of queued entries, not counting the executing segment.

## Operation
- **Reset values:** `velocity`=0, `busy`=0, `seg_done`=0, `underrun`=0, `fifo_count`=0, state IDLE, tick counter 0, remaining 0. Reset applies immediately, including mid-segment.
- **FIFO**
  - Push when `seg_valid && seg_ready` at a clock edge.
  - `seg_ready` = (`fifo_count` < DEPTH) && !`abort`. It is computed from registered count only, so a same-cycle pop never enables a push into a full FIFO.
  - Push and pop in the same cycle: count unchanged, both entries handled correctly.
  - Read and write pointers wrap modulo DEPTH.
- **IDLE:** `velocity`=0. If `fifo_count` > 0, pop the head and enter RUN:
  - `velocity` = head velocity.
  - remaining = head duration.
  - tick counter = TICK_DIV-1.
- **RUN:** the tick counter decrements every clock. When it reaches 0 (tick boundary) it reloads TICK_DIV-1, and then:
  - **remaining > 1:** remaining -= 1.
  - **remaining == 1:** the segment completes. Pulse `seg_done`.
    - FIFO non-empty: pop the next segment in the same cycle (seamless, no zero-velocity gap) and stay in RUN.
    - FIFO empty: `velocity` becomes 0, pulse `underrun`, go to IDLE.
  - **remaining == 0 (hold):** velocity is held indefinitely.
    - At the first tick boundary where the FIFO is non-empty: pulse `seg_done`, pop the next segment, stay in RUN.
    - No `underrun` is ever raised from hold.
- **abort**, sampled at an edge. It has priority over push, pop and completion:
  - FIFO flushed, `fifo_count`=0.
  - `velocity`=0, state IDLE.
  - No `seg_done` or `underrun` pulse.
  - A push presented in the same cycle is dropped (`seg_ready` is already low).
- **Arithmetic:**
  - `seg_velocity` is passed through unmodified; clamping is done downstream.
  - Durations are unsigned 32-bit; remaining never underflows.
- `busy` = (state == RUN).

## Timing
- Push into an empty FIFO while IDLE, at edge N:
  - `fifo_count`=1 after N.
  - Pop at edge N+1: `velocity` valid, `busy`=1 after N+1.
- A segment with duration D > 0 holds `velocity` for exactly D×TICK_DIV clocks.
- `seg_done` and `underrun` are asserted for the single cycle following the completing edge, coincident with the new `velocity` value.
- Outputs are glitch-free registers. `seg_ready` is the only combinational output (from `fifo_count` and `abort`).

## Test plan
- **Reset/idle:** TICK_DIV=4. Hold reset, then release → all outputs 0 and `seg_ready`=1. With no pushes for 20 cycles, `velocity` stays 0.
- **Single segment:** TICK_DIV=4. Push (1000, 3) at edge N → `velocity`=1000 from N+1 for exactly 12 clocks. Then `velocity`=0 with `seg_done` and `underrun` pulsing together for one cycle, and `busy`=0.
- **Seamless chain:** push (500,2), (-700,1), (0x7FFFFFFF,1) back to back:
  - `velocity` sequence 500×8, -700×4, 0x7FFFFFFF×4 clocks, with no zero gap.
  - Three `seg_done` pulses, `underrun` only after the last.
- **Full FIFO:** DEPTH=8. Hold `seg_valid` high with one segment executing → 8 entries accepted, `seg_ready`=0, extra offers not taken. `seg_ready` returns to 1 the cycle after the next pop. All entries are played in order.
- **Hold segment:** push (300,0) and wait 40 clocks → `velocity` stays 300 with no `underrun`. Push (100,1) → it is taken at the next tick boundary, then runs 4 clocks, then `underrun`.
- **Abort/reset mid-run:**
  - Queue 5 segments, then assert `abort` mid-segment together with `seg_valid` → next cycle `velocity`=0, `fifo_count`=0, no pulses, pushed segment dropped.
  - Repeat with async `reset` asserted between edges → outputs clear immediately.
